icarus_work_ctrl: RTL and testbench

- Host-side counterpart of the SHA-256 miner core.
- Assembles 44-byte work packets (32-byte midstate, 12-byte data2) from a received byte stream and presents them to the miner.
- Drives start_mining, tracks miner_busy/got_ticket, and returns golden_nonce as 4 bytes over a ready/valid transmit stream.
- Sits between the UART receiver/transmitter and the miner core.

---
 rtl/icarus_pkg.sv | 20 ++
 rtl/icarus_rx_assembler.sv | 51 +++++
 rtl/icarus_work_ctrl.sv | 150 +++++++++++++++
 tb/tb_icarus_work_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icarus_pkg.sv
// Shared types and sizes for the Icarus host-side work controller.
package icarus_pkg;

    localparam int unsigned WORK_BYTES  = 44;
    localparam int unsigned MIDSTATE_W  = 256;
    localparam int unsigned DATA2_W     = 96;
    localparam int unsigned NONCE_BYTES = 4;
    localparam int unsigned SR_W        = MIDSTATE_W + DATA2_W;
    localparam int unsigned BYTE_CNT_W  = $clog2(WORK_BYTES);
    localparam int unsigned TX_IDX_W    = $clog2(NONCE_BYTES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT_BUSY,
        ST_MINING,
        ST_SEND
    } state_t;

endpackage

// File: rtl/icarus_rx_assembler.sv
// Collects received bytes into a 44-byte work packet and flags completion.
module icarus_rx_assembler
    import icarus_pkg::*;
#(
    parameter int unsigned RX_TIMEOUT = 1000000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      rx_data,
    input  logic            rx_valid,
    output logic [SR_W-1:0] sr,
    output logic            pkt_done
);

    localparam int unsigned IDLE_W = $clog2(RX_TIMEOUT + 1);

    logic [BYTE_CNT_W-1:0] byte_cnt;
    logic [IDLE_W-1:0]     idle_cnt;

    // Shift in bytes, count them, and discard a partial packet after a long gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr       <= '0;
            byte_cnt <= '0;
            idle_cnt <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= 1'b0;
            if (rx_valid) begin
                sr       <= {sr[SR_W-9:0], rx_data};
                idle_cnt <= '0;
                if (byte_cnt == BYTE_CNT_W'(WORK_BYTES - 1)) begin
                    byte_cnt <= '0;
                    pkt_done <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end else if (byte_cnt != '0) begin
                if (idle_cnt == IDLE_W'(RX_TIMEOUT)) begin
                    byte_cnt <= '0;
                    idle_cnt <= '0;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end else begin
                idle_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/icarus_work_ctrl.sv
// Host-side job controller: hands assembled work to the miner and returns
// the golden nonce as four bytes over a ready/valid stream.
module icarus_work_ctrl #(
    parameter int unsigned START_HOLD = 4,
    parameter int unsigned BUSY_WAIT  = 16,
    parameter int unsigned RX_TIMEOUT = 1000000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic [255:0] midstate,
    output logic [95:0]  data2,
    output logic         start_mining,
    input  logic         miner_busy,
    input  logic         got_ticket,
    input  logic [31:0]  golden_nonce,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    output logic         job_active
);
    import icarus_pkg::*;

    localparam int unsigned HOLD_W = $clog2(START_HOLD + 1);
    localparam int unsigned WAIT_W = $clog2(BUSY_WAIT + 1);

    state_t              state;
    state_t              state_next;
    logic [SR_W-1:0]     sr;
    logic                pkt_done;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic [TX_IDX_W-1:0] tx_idx;
    logic                pending;
    logic [31:0]         nonce_r;
    logic                tx_fire;
    logic                last_byte;
    logic                enter_start;
    logic                take_ticket;

    icarus_rx_assembler #(
        .RX_TIMEOUT(RX_TIMEOUT)
    ) u_rx (
        .clk     (clk),
        .rst     (rst),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .sr      (sr),
        .pkt_done(pkt_done)
    );

    assign tx_fire     = (state == ST_SEND) && tx_ready;
    assign last_byte   = (tx_idx == TX_IDX_W'(NONCE_BYTES - 1));
    // A packet landing while already in START restarts the job with the fresh data.
    assign enter_start = (state_next == ST_START) && ((state != ST_START) || pkt_done);
    assign take_ticket = (state == ST_MINING) && (state_next == ST_SEND);

    // State register plus the job/nonce datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            midstate <= '0;
            data2    <= '0;
            hold_cnt <= '0;
            wait_cnt <= '0;
            tx_idx   <= '0;
            pending  <= 1'b0;
            nonce_r  <= '0;
        end else begin
            state <= state_next;

            if (enter_start) begin
                midstate <= sr[SR_W-1:DATA2_W];
                data2    <= sr[DATA2_W-1:0];
            end

            if ((state == ST_START) && !enter_start && (state_next == ST_START)) begin
                if (hold_cnt < HOLD_W'(START_HOLD)) hold_cnt <= hold_cnt + 1'b1;
            end else begin
                hold_cnt <= '0;
            end

            if ((state == ST_WAIT_BUSY) && (state_next == ST_WAIT_BUSY)) begin
                if (wait_cnt < WAIT_W'(BUSY_WAIT)) wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end

            if (take_ticket) begin
                nonce_r <= golden_nonce;
                tx_idx  <= '0;
            end else if (tx_fire) begin
                tx_idx <= tx_idx + 1'b1;
            end

            if (state == ST_SEND) begin
                if (tx_fire && last_byte) pending <= 1'b0;
                else if (pkt_done)        pending <= 1'b1;
            end else begin
                pending <= 1'b0;
            end
        end
    end

    // Next-state logic; a new packet always outranks a ticket.
    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (pkt_done) state_next = ST_START;
            end
            ST_START: begin
                if (pkt_done)                                   state_next = ST_START;
                else if (hold_cnt == HOLD_W'(START_HOLD - 1))   state_next = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (pkt_done)                                   state_next = ST_START;
                else if (miner_busy)                            state_next = ST_MINING;
                else if (wait_cnt == WAIT_W'(BUSY_WAIT - 1))    state_next = ST_IDLE;
            end
            ST_MINING: begin
                if (pkt_done)        state_next = ST_START;
                else if (got_ticket) state_next = ST_SEND;
                else if (!miner_busy) state_next = ST_IDLE;
            end
            ST_SEND: begin
                if (tx_fire && last_byte) state_next = (pending || pkt_done) ? ST_START : ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state; nonce goes out MSB first.
    always_comb begin
        start_mining = (state == ST_START);
        job_active   = (state == ST_START) || (state == ST_WAIT_BUSY) || (state == ST_MINING);
        tx_valid     = (state == ST_SEND);
        tx_data      = '0;
        if (state == ST_SEND) begin
            unique case (tx_idx)
                2'd0:    tx_data = nonce_r[31:24];
                2'd1:    tx_data = nonce_r[23:16];
                2'd2:    tx_data = nonce_r[15:8];
                default: tx_data = nonce_r[7:0];
            endcase
        end
    end

endmodule

// File: tb/tb_icarus_work_ctrl.sv
// Directed bench for icarus_work_ctrl: table of full jobs plus corner sequences.
module tb_icarus_work_ctrl;

    localparam int unsigned TB_TIMEOUT = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [255:0] midstate;
    logic [95:0]  data2;
    logic         start_mining;
    logic         miner_busy;
    logic         got_ticket;
    logic [31:0]  golden_nonce;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         job_active;

    icarus_work_ctrl #(
        .START_HOLD(4),
        .BUSY_WAIT (16),
        .RX_TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .midstate    (midstate),
        .data2       (data2),
        .start_mining(start_mining),
        .miner_busy  (miner_busy),
        .got_ticket  (got_ticket),
        .golden_nonce(golden_nonce),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .job_active  (job_active)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  base;
        logic [31:0] nonce;
        logic [31:0] exp_ms_top;
        logic [31:0] exp_d2_low;
        logic [31:0] exp_tx;
    } vec_t;

    vec_t vecs[4];

    int n_vec = 0;
    int n_err = 0;
    int start_rises = 0;
    int tx_cycles = 0;
    logic start_q = 1'b0;

    always @(negedge clk) begin
        if (start_mining && !start_q) start_rises <= start_rises + 1;
        start_q <= start_mining;
        if (tx_valid) tx_cycles <= tx_cycles + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] base);
        for (int i = 0; i < 44; i++) send_byte(base + 8'(i));
    endtask

    task automatic model_pkt(input logic [7:0] base, output logic [255:0] ms, output logic [95:0] d2);
        logic [351:0] s;
        s = '0;
        for (int i = 0; i < 44; i++) s = {s[343:0], 8'(base + 8'(i))};
        ms = s[351:96];
        d2 = s[95:0];
    endtask

    // Waits (bounded) for start_mining, then counts how long it stays high.
    task automatic wait_start(output int width);
        int t;
        t = 0;
        while (!start_mining && t < 20) begin
            step();
            t++;
        end
        width = 0;
        while (start_mining && width < 20) begin
            step();
            width++;
        end
    endtask

    // Collects up to four tx bytes, stalling tx_ready for 'hold' cycles per byte.
    task automatic collect(input int hold, output logic [31:0] got, output int n, output bit stable);
        logic [7:0] b0;
        got    = '0;
        n      = 0;
        stable = 1'b1;
        for (int c = 0; c < 400 && n < 4; c++) begin
            if (tx_valid) begin
                b0 = tx_data;
                for (int h = 0; h < hold; h++) begin
                    step();
                    if (!tx_valid || tx_data !== b0) stable = 1'b0;
                end
                tx_ready = 1'b1;
                step();
                tx_ready = 1'b0;
                got = {got[23:0], b0};
                n++;
            end else begin
                step();
            end
        end
    endtask

    // Drives a packet through start and into MINING with busy raised 3 cycles after start drops.
    task automatic start_and_mine(input logic [7:0] base, output int width);
        send_pkt(base);
        wait_start(width);
        step();
        step();
        miner_busy = 1'b1;
        step();
        step();
    endtask

    task automatic run_job(input vec_t v);
        int w;
        int n;
        bit stable;
        logic [31:0] got;
        logic [255:0] ms;
        logic [95:0] d2;
        send_pkt(v.base);
        wait_start(w);
        check("start_width", 32'(w), 32'd4);
        check("ms_top", midstate[255:224], v.exp_ms_top);
        check("d2_low", data2[31:0], v.exp_d2_low);
        model_pkt(v.base, ms, d2);
        check_wide("midstate", midstate, ms);
        check_wide("data2", 256'(data2), 256'(d2));
        step();
        step();
        miner_busy = 1'b1;
        step();
        step();
        golden_nonce = v.nonce;
        got_ticket   = 1'b1;
        step();
        collect(0, got, n, stable);
        check("tx_count", 32'(n), 32'd4);
        check("tx_bytes", got, v.exp_tx);
        check("tx_after", 32'(tx_valid), 32'd0);
        got_ticket = 1'b0;
        miner_busy = 1'b0;
        step();
        check("job_idle", 32'(job_active), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n;
        int r0;
        int t0;
        bit stable;
        logic [31:0] got;

        vecs[0] = '{8'h00, 32'h12345678, 32'h00010203, 32'h28292A2B, 32'h12345678};
        vecs[1] = '{8'h40, 32'h89ABCDEF, 32'h40414243, 32'h68696A6B, 32'h89ABCDEF};
        vecs[2] = '{8'hF0, 32'h00000001, 32'hF0F1F2F3, 32'h18191A1B, 32'h00000001};
        vecs[3] = '{8'h80, 32'hFFFFFF00, 32'h80818283, 32'hA8A9AAAB, 32'hFFFFFF00};

        rst          = 1'b1;
        rx_data      = '0;
        rx_valid     = 1'b0;
        miner_busy   = 1'b0;
        got_ticket   = 1'b0;
        golden_nonce = '0;
        tx_ready     = 1'b0;
        repeat (3) step();
        check("rst_start", 32'(start_mining), 32'd0);
        check("rst_txv", 32'(tx_valid), 32'd0);
        check("rst_txd", 32'(tx_data), 32'd0);
        check("rst_job", 32'(job_active), 32'd0);
        check_wide("rst_ms", midstate, 256'd0);
        check_wide("rst_d2", 256'(data2), 256'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 4; i++) run_job(vecs[i]);

        // Exhausted range: busy rises then falls, nothing is sent.
        t0 = tx_cycles;
        start_and_mine(8'h80, w);
        repeat (3) step();
        check("exh_active", 32'(job_active), 32'd1);
        miner_busy = 1'b0;
        step();
        check("exh_idle", 32'(job_active), 32'd0);
        repeat (5) step();
        check("exh_no_tx", 32'(tx_cycles - t0), 32'd0);

        // Partial packet timeout, then a clean packet; also the busy-wait drop boundary.
        r0 = start_rises;
        for (int i = 0; i < 20; i++) send_byte(8'hA0 + 8'(i));
        repeat (TB_TIMEOUT + 16) step();
        check("to_no_start", 32'(start_rises - r0), 32'd0);
        send_pkt(8'h40);
        wait_start(w);
        check("to_one_start", 32'(start_rises - r0), 32'd1);
        check("to_ms_top", midstate[255:224], 32'h40414243);
        repeat (15) step();
        check("bw_still_wait", 32'(job_active), 32'd1);
        step();
        check("bw_dropped", 32'(job_active), 32'd0);

        // Stale ticket during WAIT_BUSY must not trigger a send.
        t0 = tx_cycles;
        golden_nonce = 32'hDEADBEEF;
        got_ticket   = 1'b1;
        send_pkt(8'h00);
        wait_start(w);
        repeat (5) step();
        check("stale_wait", 32'(job_active), 32'd1);
        miner_busy = 1'b1;
        got_ticket = 1'b0;
        repeat (5) step();
        check("stale_mining", 32'(job_active), 32'd1);
        miner_busy = 1'b0;
        step();
        check("stale_idle", 32'(job_active), 32'd0);
        check("stale_no_tx", 32'(tx_cycles - t0), 32'd0);

        // Backpressured send with a new packet completing mid-send.
        start_and_mine(8'h00, w);
        golden_nonce = 32'hA1B2C3D4;
        got_ticket   = 1'b1;
        step();
        r0 = start_rises;
        fork
            send_pkt(8'h40);
            collect(12, got, n, stable);
        join
        check("bp_count", 32'(n), 32'd4);
        check("bp_bytes", got, 32'hA1B2C3D4);
        check("bp_stable", 32'(stable), 32'd1);
        check("bp_pending_start", 32'(start_mining), 32'd1);
        got_ticket = 1'b0;
        miner_busy = 1'b0;
        wait_start(w);
        check("bp_start_width", 32'(w), 32'd4);
        check("bp_ms_top", midstate[255:224], 32'h40414243);
        check("bp_one_start", 32'(start_rises - r0), 32'd1);
        repeat (20) step();

        // Abort: a new packet during MINING restarts immediately with new work.
        start_and_mine(8'h00, w);
        check("ab_mining", 32'(job_active), 32'd1);
        send_pkt(8'h80);
        step();
        check("ab_restart", 32'(start_mining), 32'd1);
        check("ab_ms_top", midstate[255:224], 32'h80818283);
        miner_busy = 1'b0;
        repeat (30) step();

        // Reset mid-send with a partial packet in flight.
        start_and_mine(8'h00, w);
        golden_nonce = 32'hCAFEF00D;
        got_ticket   = 1'b1;
        step();
        check("rs_byte0", 32'(tx_data), 32'h000000CA);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("rs_byte1", 32'(tx_data), 32'h000000FE);
        for (int i = 0; i < 10; i++) send_byte(8'h55);
        rst = 1'b1;
        step();
        check("rs_txv", 32'(tx_valid), 32'd0);
        check("rs_txd", 32'(tx_data), 32'd0);
        check("rs_start", 32'(start_mining), 32'd0);
        check("rs_job", 32'(job_active), 32'd0);
        check_wide("rs_ms", midstate, 256'd0);
        check_wide("rs_d2", 256'(data2), 256'd0);
        rst        = 1'b0;
        miner_busy = 1'b0;
        got_ticket = 1'b0;
        step();
        r0 = start_rises;
        send_pkt(8'h40);
        wait_start(w);
        check("rs_one_start", 32'(start_rises - r0), 32'd1);
        check("rs_ms_top", midstate[255:224], 32'h40414243);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
